hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard unit.
- Tracks in-flight destination writes across a configurable memory depth (LD_LAT stages) and NWP register write ports per instruction.
- Produces stall, flush and forwarding selects for the E-stage ALU operands, plus saturating stall and flush event counters.
- Sits between the controller and the datapath, fed from the D stage and from PCSrcE.

Parameters:
- NREG, 16: architectural register count; RW = clog2(NREG).
- NWP, 2: destination write ports per instruction, range 1..4; PW = max(1, clog2(NWP)).
- LD_LAT, 1: number of memory stages M1..M_LD_LAT, range 1..4; SW = clog2(LD_LAT+2).
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ValidD  in  1  D-stage instruction valid.
- RA1D  in  RW  source A register.
- RA2D  in  RW  source B register.
- Use1D  in  1  source A is read.
- Use2D  in  1  source B is read.
- WAD  in  NWP*RW  destination registers; port p occupies bits [p*RW +: RW].
- WED  in  NWP  per-port write enables.
- LoadD  in  1  instruction is a load; all of its enabled ports return memory data.
- PCSrcE  in  1  branch taken, resolved in E.
- StallF  out  1  hold PC.
- StallD  out  1  hold D register.
- FlushD  out  1  bubble D.
- FlushE  out  1  bubble E.
- ForwardAE  out  PW+SW  operand A select, {port, stage}.
- ForwardBE  out  PW+SW  operand B select, {port, stage}.
- StallCount  out  CNT_W  stall cycles.
- FlushCount  out  CNT_W  taken-branch flushes.

Behaviour:
In-flight table:
- Shift register of LD_LAT+2 slots. Index 0 = E, 1..LD_LAT = M stages, LD_LAT+1 = W.
- Each slot holds valid, load, and per-port {addr, en}.
- Every cycle, slot k moves to slot k+1; the W slot retires.
- Slot 0 loads the D-stage instruction when ValidD & ~StallD & ~PCSrcE; otherwise slot 0 loads a bubble (valid = 0).
- The block also registers RA1D/RA2D/Use1D/Use2D into E copies under the same load or bubble condition.

Availability:
- ALU result is forwardable from stage index ≥ 1.
- Load result is forwardable only from index LD_LAT+1.
- The register file is write-before-read, so W results are visible in D and need no D-side check.

Forwarding (combinational, from the E copies and slots 1..LD_LAT+1):
- A match requires: slot valid, port en, addr equal to the E source, Use set, and the slot available.
- The youngest matching slot (lowest index) wins.
- Within one slot, the highest port index wins.
- Output = {port, stage index}.
- No match, or Use = 0, gives 0 (register file).
- A match on an unavailable slot cannot occur because of the stall rule; in that case the output is 0.

Load-use stall:
- Hazard when ValidD, a used D source matches an enabled port of a valid load slot at index s, and s+1 < LD_LAT+1.
- StallF = StallD = hazard & ~PCSrcE.

Flush:
- FlushD = PCSrcE.
- FlushE = PCSrcE | StallD.
- PCSrcE has priority over stall: a simultaneous hazard produces no stall.

Counters:
- StallCount increments each cycle StallD = 1.
- FlushCount increments each cycle PCSrcE = 1.
- Both saturate at all-ones (no wrap).

Reset (reset = 0 at a rising edge):
- Clears all slot valids, E copies and counters.
- While reset = 0, every output is forced to 0.
- Reset asserted mid-stall clears the hazard the next cycle.

Boundary conditions:
- ValidD = 0 never stalls.
- Matching WE = 0 ports are ignored.
- Duplicate destinations on two ports of one instruction resolve to the highest port.

Test Plan (defaults: NREG=16, NWP=2, LD_LAT=1; stages E=0, M=1, W=2):
1. ALU instruction writes r3 (port0); next instruction reads r3 on A -> no stall; that cycle in E, ForwardAE = {0, 1}. One instruction later, the same read gives {0, 2}.
2. Load writes r5; next instruction reads r5 on B -> StallD = StallF = FlushE = 1 for exactly 1 cycle; then ForwardBE = {0, 2}; StallCount = 1.
3. Load writes r5 while PCSrcE = 1 in the same cycle as the dependent instruction in D -> StallD = 0, FlushD = FlushE = 1; FlushCount = 1; dependent instruction never occupies slot 0.
4. Producer in M writes r2 on port1 while an older producer in W writes r2 on port0; consumer in E reads r2 -> ForwardAE = {1, 1}. Same-slot duplicates on port0 and port1 -> port field = 1.
5. LD_LAT = 3 build: load writes r7, next instruction reads r7 -> 3 stall cycles, then forward from stage 4.
6. Drive 70000 stall cycles with CNT_W = 16 -> StallCount holds at 0xFFFF. Assert reset low -> all outputs 0; counters 0 after release.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Desc     : D-stage request and hazard-response bundle shared by the
//            controller (master) and the hazard scoreboard (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int NREG   = 16,
    parameter int NWP    = 2,
    parameter int LD_LAT = 1,
    parameter int CNT_W  = 16
);
    localparam int c_RW = $clog2(NREG);
    localparam int c_PW = (NWP > 1) ? $clog2(NWP) : 1;
    localparam int c_SW = $clog2(LD_LAT + 2);

    logic                   ValidD;
    logic [c_RW-1:0]        RA1D;
    logic [c_RW-1:0]        RA2D;
    logic                   Use1D;
    logic                   Use2D;
    logic [NWP*c_RW-1:0]    WAD;
    logic [NWP-1:0]         WED;
    logic                   LoadD;
    logic                   PCSrcE;

    logic                   StallF;
    logic                   StallD;
    logic                   FlushD;
    logic                   FlushE;
    logic [c_PW+c_SW-1:0]   ForwardAE;
    logic [c_PW+c_SW-1:0]   ForwardBE;
    logic [CNT_W-1:0]       StallCount;
    logic [CNT_W-1:0]       FlushCount;

    modport master (
        output ValidD, RA1D, RA2D, Use1D, Use2D, WAD, WED, LoadD, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );

    modport slave (
        input  ValidD, RA1D, RA2D, Use1D, Use2D, WAD, WED, LoadD, PCSrcE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Desc     : In-flight write tracker producing load-use stalls, branch
//            flushes, E-stage forwarding selects and saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG   = 16,
    parameter int NWP    = 2,
    parameter int LD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    hazard_scoreboard_if.slave sb
);
    localparam int c_RW    = $clog2(NREG);
    localparam int c_PW    = (NWP > 1) ? $clog2(NWP) : 1;
    localparam int c_SW    = $clog2(LD_LAT + 2);
    localparam int c_FW    = c_PW + c_SW;
    localparam int c_NSLOT = LD_LAT + 2;
    localparam int c_WIDX  = LD_LAT + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Slot 0 = E, 1..LD_LAT = memory stages, c_WIDX = W
    logic [c_NSLOT-1:0]     r_slotValid;
    logic [c_NSLOT-1:0]     r_slotLoad;
    logic [NWP-1:0]         r_slotEn   [c_NSLOT];
    logic [NWP*c_RW-1:0]    r_slotAddr [c_NSLOT];

    logic [c_RW-1:0]        r_srcE [2];
    logic [1:0]             r_useE;
    logic [CNT_W-1:0]       r_stallCount;
    logic [CNT_W-1:0]       r_flushCount;

    logic                   w_hazard;
    logic                   w_stall;
    logic                   w_issue;
    logic [c_FW-1:0]        w_fwd [2];

    // A load in slot s is still unavailable to the instruction in D when it
    // would not yet have reached W by the time D advances into E.
    always_comb begin
        w_hazard = 1'b0;
        for (int s = 0; s < LD_LAT; s++) begin
            for (int p = 0; p < NWP; p++) begin
                if (r_slotValid[s] && r_slotLoad[s] && r_slotEn[s][p] &&
                    ((sb.Use1D && (r_slotAddr[s][p*c_RW +: c_RW] == sb.RA1D)) ||
                     (sb.Use2D && (r_slotAddr[s][p*c_RW +: c_RW] == sb.RA2D)))) begin
                    w_hazard = 1'b1;
                end
            end
        end
        w_hazard = w_hazard & sb.ValidD;
    end

    assign w_stall = w_hazard & ~sb.PCSrcE;
    assign w_issue = sb.ValidD & ~w_stall & ~sb.PCSrcE;

    // Oldest slot scanned first so younger matches overwrite; ascending ports
    // let the highest matching port win inside a slot.
    always_comb begin
        w_fwd[0] = '0;
        w_fwd[1] = '0;
        for (int o = 0; o < 2; o++) begin
            for (int k = c_NSLOT - 1; k >= 1; k--) begin
                for (int p = 0; p < NWP; p++) begin
                    if (r_useE[o] && r_slotValid[k] && r_slotEn[k][p] &&
                        (r_slotAddr[k][p*c_RW +: c_RW] == r_srcE[o])) begin
                        w_fwd[o] = (!r_slotLoad[k] || (k == c_WIDX)) ?
                                   {c_PW'(p), c_SW'(k)} : '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slotValid  <= '0;
            r_slotLoad   <= '0;
            r_useE       <= '0;
            r_srcE[0]    <= '0;
            r_srcE[1]    <= '0;
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            r_slotValid <= {r_slotValid[c_NSLOT-2:0], w_issue};
            r_slotLoad  <= {r_slotLoad[c_NSLOT-2:0], w_issue & sb.LoadD};
            r_useE      <= w_issue ? {sb.Use2D, sb.Use1D} : 2'b00;
            r_srcE[0]   <= w_issue ? sb.RA1D : '0;
            r_srcE[1]   <= w_issue ? sb.RA2D : '0;
            if (w_stall && (r_stallCount != c_CNT_MAX)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            if (sb.PCSrcE && (r_flushCount != c_CNT_MAX)) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

    // Address/enable payload is qualified by the slot valid, so it needs no reset
    always_ff @(posedge clk) begin
        r_slotEn[0]   <= w_issue ? sb.WED : '0;
        r_slotAddr[0] <= sb.WAD;
        for (int k = 1; k < c_NSLOT; k++) begin
            r_slotEn[k]   <= r_slotEn[k-1];
            r_slotAddr[k] <= r_slotAddr[k-1];
        end
    end

    assign sb.StallF     = reset & w_stall;
    assign sb.StallD     = reset & w_stall;
    assign sb.FlushD     = reset & sb.PCSrcE;
    assign sb.FlushE     = reset & (sb.PCSrcE | w_stall);
    assign sb.ForwardAE  = reset ? w_fwd[0] : '0;
    assign sb.ForwardBE  = reset ? w_fwd[1] : '0;
    assign sb.StallCount = reset ? r_stallCount : '0;
    assign sb.FlushCount = reset ? r_flushCount : '0;
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// Bench for hazard_scoreboard: directed and random D-stage traffic scored
// against a timestamped list of in-flight instructions.
module tb_hazard_scoreboard;
    localparam int NREG    = 16;
    localparam int NWP     = 2;
    localparam int LD_LAT  = 2;
    localparam int CNT_W   = 8;
    localparam int RW      = $clog2(NREG);
    localparam int SW      = $clog2(LD_LAT + 2);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG), .NWP(NWP), .LD_LAT(LD_LAT), .CNT_W(CNT_W)) hif ();

    hazard_scoreboard #(.NREG(NREG), .NWP(NWP), .LD_LAT(LD_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (hif.slave)
    );

    typedef struct {
        int               t;
        bit               load;
        bit [NWP-1:0]     en;
        bit [NWP*RW-1:0]  addr;
    } rec_t;

    typedef struct {
        bit stallF, stallD, flushD, flushE;
        int fwdA, fwdB, stallCnt, flushCnt;
    } exp_t;

    rec_t inflight[$];
    exp_t expQ[$];

    int nAssert = 0;
    int nFail   = 0;

    // Model state: now = cycle index; an instruction's stage is now - t
    int   now = 0;
    int   eRa1, eRa2;
    bit   eUse1, eUse2;
    int   stallCnt, flushCnt;
    bit   pRstN, pIssue, pStall, pPc;
    rec_t pRec;
    int   pRa1, pRa2;
    bit   pUse1, pUse2;
    bit   lastStall;

    bit               dRstN;
    bit               dValid, dUse1, dUse2, dLoad, dPc;
    int               dRa1, dRa2;
    bit [NWP-1:0]     dWe;
    bit [NWP*RW-1:0]  dWa;

    function automatic void check(string name, int act, int exp);
        nAssert++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int hitPort(rec_t r, int a);
        int hp = -1;
        for (int p = 0; p < NWP; p++)
            if (r.en[p] && (int'(r.addr[p*RW +: RW]) == a)) hp = p;
        return hp;
    endfunction

    function automatic bit modelHazard();
        if (!dValid) return 1'b0;
        foreach (inflight[i]) begin
            int st = now - inflight[i].t;
            if (inflight[i].load && (st < LD_LAT) &&
                ((dUse1 && hitPort(inflight[i], dRa1) >= 0) ||
                 (dUse2 && hitPort(inflight[i], dRa2) >= 0)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int modelFwd(int src, bit useSrc);
        int bestSt   = -1;
        int bestPort = 0;
        bit bestLoad = 1'b0;
        if (!useSrc) return 0;
        foreach (inflight[i]) begin
            int st = now - inflight[i].t;
            int hp = hitPort(inflight[i], src);
            if (st >= 1 && st <= LD_LAT + 1 && hp >= 0 && (bestSt < 0 || st < bestSt)) begin
                bestSt   = st;
                bestPort = hp;
                bestLoad = inflight[i].load;
            end
        end
        if (bestSt < 0) return 0;
        if (bestLoad && bestSt != LD_LAT + 1) return 0;
        return (bestPort << SW) | bestSt;
    endfunction

    task automatic cycle();
        exp_t e;
        bit   haz;
        @(posedge clk);
        if (!pRstN) begin
            inflight.delete();
            eRa1 = 0; eRa2 = 0; eUse1 = 0; eUse2 = 0;
            stallCnt = 0; flushCnt = 0;
        end else begin
            if (pIssue) inflight.push_back(pRec);
            eRa1  = pIssue ? pRa1 : 0;
            eRa2  = pIssue ? pRa2 : 0;
            eUse1 = pIssue && pUse1;
            eUse2 = pIssue && pUse2;
            if (pStall && stallCnt < CNT_MAX) stallCnt++;
            if (pPc && flushCnt < CNT_MAX) flushCnt++;
        end
        now++;
        while (inflight.size() > 0 && (now - inflight[0].t) > LD_LAT + 1)
            void'(inflight.pop_front());
        #1;
        reset      = dRstN;
        hif.ValidD = dValid;
        hif.RA1D   = RW'(dRa1);
        hif.RA2D   = RW'(dRa2);
        hif.Use1D  = dUse1;
        hif.Use2D  = dUse2;
        hif.WAD    = dWa;
        hif.WED    = dWe;
        hif.LoadD  = dLoad;
        hif.PCSrcE = dPc;
        haz = modelHazard();
        if (dRstN) begin
            e.stallD   = haz && !dPc;
            e.stallF   = e.stallD;
            e.flushD   = dPc;
            e.flushE   = dPc || e.stallD;
            e.fwdA     = modelFwd(eRa1, eUse1);
            e.fwdB     = modelFwd(eRa2, eUse2);
            e.stallCnt = stallCnt;
            e.flushCnt = flushCnt;
        end else begin
            e = '{default: 0};
        end
        expQ.push_back(e);
        pRstN     = dRstN;
        pStall    = dRstN && e.stallD;
        pPc       = dRstN && dPc;
        pIssue    = dValid && !e.stallD && !dPc;
        pRec.t    = now + 1;
        pRec.load = dLoad;
        pRec.en   = dWe;
        pRec.addr = dWa;
        pRa1 = dRa1; pRa2 = dRa2; pUse1 = dUse1; pUse2 = dUse2;
        lastStall = e.stallD;
    endtask

    task automatic setD(bit v, int ra1, bit u1, int ra2, bit u2,
                        int wa0, bit we0, int wa1, bit we1, bit ld, bit pc);
        dValid = v; dRa1 = ra1; dUse1 = u1; dRa2 = ra2; dUse2 = u2;
        dWa = {RW'(wa1), RW'(wa0)};
        dWe = {we1, we0};
        dLoad = ld; dPc = pc;
    endtask

    // Present one instruction and hold it in D for as long as it is stalled
    task automatic issueD(bit v, int ra1, bit u1, int ra2, bit u2,
                          int wa0, bit we0, int wa1, bit we1, bit ld, bit pc);
        int guard = 0;
        setD(v, ra1, u1, ra2, u2, wa0, we0, wa1, we1, ld, pc);
        cycle();
        dPc = 1'b0;
        while (lastStall && guard < 16) begin
            cycle();
            guard++;
        end
        if (lastStall) begin
            nFail++;
            $display("FAIL stallBound: stall still asserted after %0d cycles", guard);
        end
    endtask

    task automatic bubble(int n);
        for (int i = 0; i < n; i++) begin
            setD(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("StallF",     int'(hif.StallF),     int'(e.stallF));
            check("StallD",     int'(hif.StallD),     int'(e.stallD));
            check("FlushD",     int'(hif.FlushD),     int'(e.flushD));
            check("FlushE",     int'(hif.FlushE),     int'(e.flushE));
            check("ForwardAE",  int'(hif.ForwardAE),  e.fwdA);
            check("ForwardBE",  int'(hif.ForwardBE),  e.fwdB);
            check("StallCount", int'(hif.StallCount), e.stallCnt);
            check("FlushCount", int'(hif.FlushCount), e.flushCnt);
        end
    end

    initial begin
        hif.ValidD = 0; hif.RA1D = '0; hif.RA2D = '0; hif.Use1D = 0; hif.Use2D = 0;
        hif.WAD = '0; hif.WED = '0; hif.LoadD = 0; hif.PCSrcE = 0;

        dRstN = 1'b0;
        bubble(3);
        dRstN = 1'b1;
        bubble(2);

        // ALU producer of r3, then two consecutive readers
        issueD(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        issueD(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issueD(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bubble(4);

        // Load r5 followed by a reader on B
        issueD(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0);
        issueD(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        bubble(4);

        // Load r5, dependent arrives with a taken branch
        issueD(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0);
        issueD(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1);
        bubble(4);

        // Older writer r2 on port0, younger on port1, then a reader
        issueD(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        issueD(1, 0, 0, 0, 0, 9, 0, 2, 1, 0, 0);
        issueD(1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 0);
        bubble(4);
        issueD(1, 0, 0, 0, 0, 2, 1, 2, 1, 0, 0);
        issueD(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bubble(4);

        // Disabled port match, and invalid D, must not stall
        issueD(1, 0, 0, 0, 0, 4, 0, 4, 0, 1, 0);
        issueD(1, 4, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        issueD(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0);
        setD(0, 6, 1, 6, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        bubble(4);

        // Reset asserted during a stall
        issueD(1, 0, 0, 0, 0, 6, 1, 0, 0, 1, 0);
        setD(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        dRstN = 1'b0;
        cycle();
        dRstN = 1'b1;
        cycle();
        bubble(3);

        // Self-dependent load chain drives StallCount to saturation
        setD(1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 450; i++) cycle();
        bubble(3);

        for (int n = 0; n < 3000; n++) begin
            if (!lastStall || $urandom_range(0, 9) == 0) begin
                dValid = ($urandom_range(0, 9) < 8);
                dRa1   = $urandom_range(0, 3);
                dRa2   = $urandom_range(0, 3);
                dUse1  = $urandom_range(0, 1);
                dUse2  = $urandom_range(0, 1);
                dWa    = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3))};
                dWe    = NWP'($urandom_range(0, 3));
                dLoad  = ($urandom_range(0, 2) == 0);
            end
            dPc   = ($urandom_range(0, 9) == 0);
            dRstN = ($urandom_range(0, 199) != 0);
            cycle();
        end

        dRstN = 1'b0;
        bubble(2);
        dRstN = 1'b1;
        bubble(3);

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
`default_nettype wire
